// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command wrapper and the command block.
package uart_cmd_pkg;

    localparam int CMD_BYTES = 3;
    localparam int CMD_W     = 8 * CMD_BYTES;

    localparam logic [7:0] RESP_ACK = 8'hA5;
    localparam logic [7:0] RESP_NAK = 8'hEE;

    typedef enum logic [1:0] {
        WAIT0,
        WAIT1,
        WAIT2,
        HOLD
    } rx_state_t;

    typedef enum logic {
        TX_IDLE,
        TX_BUSY
    } tx_state_t;

endpackage

// File: rtl/resp_tx_ctrl.sv
// Forwards one response byte at a time to the UART transmitter and reports completion.
module resp_tx_ctrl
    import uart_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] resp_data,
    input  logic       send_resp,
    input  logic       tx_done,
    output logic [7:0] tx_data,
    output logic       trmt,
    output logic       resp_sent
);

    tx_state_t  state_q, state_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       trmt_q, trmt_d;
    logic       resp_sent_q, resp_sent_d;

    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        trmt_d      = 1'b0;
        resp_sent_d = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (send_resp) begin
                    tx_data_d = resp_data;
                    trmt_d    = 1'b1;
                    state_d   = TX_BUSY;
                end
            end
            TX_BUSY: begin
                // New requests are dropped until the transmitter reports done.
                if (tx_done) begin
                    resp_sent_d = 1'b1;
                    state_d     = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= TX_IDLE;
            tx_data_q   <= 8'h00;
            trmt_q      <= 1'b0;
            resp_sent_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_data_q   <= tx_data_d;
            trmt_q      <= trmt_d;
            resp_sent_q <= resp_sent_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign trmt      = trmt_q;
    assign resp_sent = resp_sent_q;

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Assembles three received UART bytes into a held 24-bit command, with an
// inter-byte timeout, and forwards single response bytes to the transmitter.
module uart_cmd_wrapper
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_rdy,
    input  logic [7:0]       rx_data,
    output logic             clr_rx_rdy,
    output logic [CMD_W-1:0] cmd,
    output logic             cmd_rdy,
    input  logic             clr_cmd_rdy,
    output logic             timeout_err,
    input  logic [7:0]       resp_data,
    input  logic             send_resp,
    output logic             resp_sent,
    output logic [7:0]       tx_data,
    output logic             trmt,
    input  logic             tx_done
);

    localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam int               BUF_W     = CMD_W - 8;

    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic             cmd_rdy_q, cmd_rdy_d;
    logic             cap_q;
    logic             capture;
    logic             timeout;

    // cap_q blocks a second capture while the receiver is still dropping rx_rdy.
    always_comb begin
        capture = !rst && rx_rdy && !cap_q && (rx_state_q != HOLD);
        cnt_inc = cnt_q + CNT_W'(1);
    end

    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = '0;
        buf_d      = buf_q;
        cmd_d      = cmd_q;
        cmd_rdy_d  = cmd_rdy_q;
        timeout    = 1'b0;
        case (rx_state_q)
            WAIT0: begin
                if (capture) begin
                    buf_d[BUF_W-1 -: 8] = rx_data;
                    rx_state_d          = WAIT1;
                end
            end
            WAIT1, WAIT2: begin
                if (capture) begin
                    if (rx_state_q == WAIT1) begin
                        buf_d[7:0] = rx_data;
                        rx_state_d = WAIT2;
                    end else begin
                        // cmd only changes when a full frame is in, so a timed-out
                        // partial frame never shows up on the output.
                        cmd_d      = {buf_q, rx_data};
                        cmd_rdy_d  = 1'b1;
                        rx_state_d = HOLD;
                    end
                end else if (!rst && cnt_inc == CNT_LIMIT) begin
                    timeout    = 1'b1;
                    rx_state_d = WAIT0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HOLD: begin
                if (clr_cmd_rdy) begin
                    cmd_rdy_d  = 1'b0;
                    rx_state_d = WAIT0;
                end
            end
            default: rx_state_d = WAIT0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= WAIT0;
            cnt_q      <= '0;
            buf_q      <= '0;
            cmd_q      <= '0;
            cmd_rdy_q  <= 1'b0;
            cap_q      <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            cmd_q      <= cmd_d;
            cmd_rdy_q  <= cmd_rdy_d;
            cap_q      <= capture;
        end
    end

    assign clr_rx_rdy  = capture;
    assign timeout_err = timeout;
    assign cmd         = cmd_q;
    assign cmd_rdy     = cmd_rdy_q;

    resp_tx_ctrl u_resp_tx_ctrl (
        .clk       (clk),
        .rst       (rst),
        .resp_data (resp_data),
        .send_resp (send_resp),
        .tx_done   (tx_done),
        .tx_data   (tx_data),
        .trmt      (trmt),
        .resp_sent (resp_sent)
    );

endmodule

// File: doc/uart_cmd_wrapper.md
# uart_cmd_wrapper

Sits between the UART byte receiver/transmitter and the command-configuration block. Assembles three consecutive received bytes into a 24-bit command, holds it with `cmd_rdy` until the command block clears it, and abandons a partial frame if the line goes quiet. In the other direction it forwards single response bytes from the command block to the UART transmitter and returns a `resp_sent` pulse.

## Interface
- `TIMEOUT_CYCLES`, default 1_000_000: idle clock cycles allowed between bytes of one frame before the partial frame is discarded.
- `clk`  in  1  system clock; the block uses this one clock only.
- `rst`  in  1  reset, synchronous and active-high.
- `rx_rdy`  in  1  receiver has a byte; level, held until cleared.
- `rx_data`  in  8  received byte, valid while `rx_rdy`=1.
- `clr_rx_rdy`  out  1  one-cycle pulse consuming the current byte.
- `cmd`  out  24  assembled command; first byte in [23:16], second in [15:8], third in [7:0].
- `cmd_rdy`  out  1  registered level; `cmd` is complete and stable.
- `clr_cmd_rdy`  in  1  pulse from the command block; releases the held command.
- `timeout_err`  out  1  one-cycle pulse when a partial frame is discarded.
- `resp_data`  in  8  response byte, sampled on `send_resp`.
- `send_resp`  in  1  pulse requesting transmission of `resp_data`.
- `resp_sent`  out  1  one-cycle pulse when the transmitter has finished the byte.
- `tx_data`  out  8  byte to the transmitter.
- `trmt`  out  1  one-cycle pulse starting transmission.
- `tx_done`  in  1  one-cycle pulse from the transmitter at the end of the stop bit.

## Operation
- Receive FSM states: `WAIT0`, `WAIT1`, `WAIT2`, `HOLD`.
- `WAIT0`/`WAIT1`/`WAIT2`: a byte is captured when `rx_rdy`=1 and no byte was captured in the previous cycle. This one-cycle guard covers the clear latency.
- On capture, `clr_rx_rdy`=1 combinationally in the same cycle. The byte is written to the next `cmd` slot, and the FSM advances `WAIT0`→`WAIT1`→`WAIT2`→`HOLD`.
- On entering `HOLD`, `cmd_rdy`←1 and `cmd` is frozen.
- `HOLD`:
  - `rx_rdy` is ignored: no capture and no `clr_rx_rdy`. The byte stays pending in the receiver.
  - `clr_cmd_rdy`=1 → `cmd_rdy`←0 and the FSM goes to `WAIT0`. `cmd` keeps its value until it is overwritten.
- Timeout counter:
  - Width is $clog2(TIMEOUT_CYCLES+1).
  - It is held at 0 in `WAIT0` and `HOLD`, is zeroed on every capture, and otherwise increments in `WAIT1`/`WAIT2`.
  - When it reaches `TIMEOUT_CYCLES-1` with no capture in that cycle: `timeout_err`=1 for that cycle, the FSM goes to `WAIT0`, and the partial bytes are discarded. `cmd` is left unchanged, with no visible partial update required.
  - A capture in that same cycle wins; there is no timeout.
- Transmit FSM states: `TX_IDLE`, `TX_BUSY`.
  - `TX_IDLE` with `send_resp`=1: `tx_data`←`resp_data`, `trmt`←1 (registered, so visible the next cycle, for one cycle), then → `TX_BUSY`.
  - `TX_BUSY`: `send_resp` is ignored. On `tx_done`: `resp_sent`←1 (registered, one cycle), then → `TX_IDLE`.
- The receive and transmit paths are independent and may run concurrently.
- Reset values:
  - `cmd`=0, `cmd_rdy`=0, `timeout_err`=0, `clr_rx_rdy`=0.
  - `tx_data`=0, `trmt`=0, `resp_sent`=0.
  - Both FSMs go to their idle states and the counter to 0.
  - A reset in mid-frame or mid-transmit drops the frame or transaction with no further pulses.

## Timing
- Third byte captured in cycle N → `cmd_rdy`=1 in cycle N+1.
- `clr_cmd_rdy` in cycle M → `cmd_rdy`=0 in M+1. The earliest next capture is in M+1.
- `send_resp` in cycle K → `trmt`=1 and `tx_data` valid in K+1.
- `tx_done` in cycle T → `resp_sent`=1 in T+1. The earliest accepted `send_resp` is T+1.
- Back-to-back bytes: `rx_rdy` re-asserted in the cycle right after a capture is not sampled until the cycle after that.

## Structure
- Package `uart_cmd_pkg`:
  - `rx_state_t` and `tx_state_t` enums.
  - `CMD_BYTES`=3.
  - Response constants `RESP_ACK`=8'hA5 and `RESP_NAK`=8'hEE, shared with the command-configuration block.
- Sub-module `resp_tx_ctrl` implements the transmit FSM with `tx_data`, `trmt` and `resp_sent`.
- The receive FSM and the timeout counter stay in the top level.

## Test plan
- Send bytes 0x03, 0x00, 0x80 with gaps → `cmd`=24'h030080 and `cmd_rdy`=1 one cycle after the third capture; exactly three `clr_rx_rdy` pulses.
- Send 0x06 while `cmd_rdy`=1 → no `clr_rx_rdy` and `cmd` unchanged. After `clr_cmd_rdy`, 0x06 is captured as the first byte.
- `TIMEOUT_CYCLES`=16; send one byte and then nothing → `timeout_err` pulses 15 cycles after the capture. The next three bytes 0x01, 0x02, 0x03 give `cmd`=24'h010203.
- `send_resp` with `resp_data`=0xA5 → `trmt` one cycle later with `tx_data`=0xA5. A second `send_resp` while busy is ignored. `tx_done` → `resp_sent` one cycle later.
- Assert `rst` after the second byte and during `TX_BUSY` → all outputs 0 next cycle; three new bytes then assemble correctly.
- Third byte captured in the same cycle the counter hits its limit → no `timeout_err` and `cmd_rdy`=1.
